// File: rtl/memory_access_unit.sv
// Memory-stage load/store engine: runs one data-bus transaction per access
// (waitrequest handshake), builds lane enables / replicated store data and
// returns the sign/zero-extended load result. Stalls the pipeline until done.
module memory_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_read_memory,
    input  logic        memory_write_memory,
    input  logic [2:0]  access_type_memory,
    input  logic [31:0] ALU_output_memory,
    input  logic [31:0] write_data_memory,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [3:0]  data_byteenable,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata,
    input  logic        data_waitrequest,
    output logic [31:0] read_data_memory,
    output logic        stall_memory,
    output logic        address_error_memory
);

    typedef enum logic [1:0] {StIdle, StBus, StDone} state_t;

    state_t      state_q, state_d;
    logic        is_write, is_read, access, is_byte, is_half, misaligned, start;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  lane_q;
    logic [2:0]  type_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    // Decode the access presented by the memory stage; store wins over load.
    always_comb begin
        is_write   = memory_write_memory;
        is_read    = memory_read_memory & ~memory_write_memory;
        access     = is_write | is_read;
        is_byte    = (access_type_memory[1:0] == 2'b00);
        is_half    = (access_type_memory[1:0] == 2'b01);
        misaligned = is_half ? ALU_output_memory[0]
                   : (!is_byte && (ALU_output_memory[1:0] != 2'b00));
        start      = access & ~misaligned;
        if (is_byte) begin
            be    = 4'b0001 << ALU_output_memory[1:0];
            wdata = {4{write_data_memory[7:0]}};
        end else if (is_half) begin
            be    = ALU_output_memory[1] ? 4'b1100 : 4'b0011;
            wdata = {2{write_data_memory[15:0]}};
        end else begin
            be    = 4'b1111;
            wdata = write_data_memory;
        end
    end

    // Extract the addressed lane(s) of the returned word and extend them.
    always_comb begin
        unique case (lane_q)
            2'd0:    ld_byte = data_readdata[7:0];
            2'd1:    ld_byte = data_readdata[15:8];
            2'd2:    ld_byte = data_readdata[23:16];
            default: ld_byte = data_readdata[31:24];
        endcase
        ld_half = lane_q[1] ? data_readdata[31:16] : data_readdata[15:0];
        unique case (type_q[1:0])
            2'b00:   load_ext = type_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = type_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_ext = data_readdata;
        endcase
    end

    // Next state, stall and misalignment flag.
    always_comb begin
        state_d              = state_q;
        stall_memory         = 1'b0;
        address_error_memory = 1'b0;
        unique case (state_q)
            StIdle: begin
                address_error_memory = access & misaligned;
                stall_memory         = start;
                if (start) state_d = StBus;
            end
            StBus: begin
                stall_memory = 1'b1;
                if (!data_waitrequest) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, bus registers and load result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            data_address     <= 32'h0;
            data_read        <= 1'b0;
            data_write       <= 1'b0;
            data_byteenable  <= 4'h0;
            data_writedata   <= 32'h0;
            read_data_memory <= 32'h0;
            lane_q           <= 2'b00;
            type_q           <= 3'b000;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        data_address    <= {ALU_output_memory[31:2], 2'b00};
                        data_read       <= is_read;
                        data_write      <= is_write;
                        data_byteenable <= be;
                        data_writedata  <= wdata;
                        lane_q          <= ALU_output_memory[1:0];
                        type_q          <= access_type_memory;
                    end
                end
                StBus: begin
                    if (!data_waitrequest) begin
                        data_read  <= 1'b0;
                        data_write <= 1'b0;
                        if (data_read) read_data_memory <= load_ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: scoreboard of expected load
// results, bus responder with programmable wait states, reference memory.
module tb_memory_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        memory_read_memory, memory_write_memory;
    logic [2:0]  access_type_memory;
    logic [31:0] ALU_output_memory, write_data_memory;
    logic [31:0] data_address, data_writedata, data_readdata, read_data_memory;
    logic        data_read, data_write, data_waitrequest, stall_memory, address_error_memory;
    logic [3:0]  data_byteenable;

    int          n_vec = 0;
    int          n_err = 0;
    int          wait_cfg = 0;
    int          wait_cnt;
    logic [31:0] bus_mem [64];
    logic [31:0] ref_mem [64];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd = 32'h0;

    always #5 clk = ~clk;

    memory_access_unit dut (
        .clk                  (clk),
        .reset                (reset),
        .memory_read_memory   (memory_read_memory),
        .memory_write_memory  (memory_write_memory),
        .access_type_memory   (access_type_memory),
        .ALU_output_memory    (ALU_output_memory),
        .write_data_memory    (write_data_memory),
        .data_address         (data_address),
        .data_read            (data_read),
        .data_write           (data_write),
        .data_byteenable      (data_byteenable),
        .data_writedata       (data_writedata),
        .data_readdata        (data_readdata),
        .data_waitrequest     (data_waitrequest),
        .read_data_memory     (read_data_memory),
        .stall_memory         (stall_memory),
        .address_error_memory (address_error_memory)
    );

    // Bus slave: inserts wait_cfg wait states per transaction.
    always @(posedge clk or posedge reset) begin
        if (reset) wait_cnt <= 0;
        else if (data_read || data_write) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign data_waitrequest = (data_read || data_write) && (wait_cnt < wait_cfg);
    assign data_readdata    = bus_mem[data_address[7:2]];

    // Bus slave write port.
    always @(posedge clk) begin
        if (data_write && !data_waitrequest) begin
            for (int l = 0; l < 4; l++)
                if (data_byteenable[l]) bus_mem[data_address[7:2]][8*l +: 8] <= data_writedata[8*l +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] ty);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (ty)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] ty, input logic [1:0] a);
        case (ty[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] ty, input logic [31:0] d);
        case (ty[1:0])
            2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
            2'b01:   return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    task automatic clear_inputs();
        memory_read_memory  = 1'b0;
        memory_write_memory = 1'b0;
        access_type_memory  = 3'b010;
        ALU_output_memory   = 32'h0;
        write_data_memory   = 32'h0;
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        bus_mem[idx] <= val;
        ref_mem[idx] = val;
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the next IDLE negedge.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] ty,
                              input logic [31:0] addr, input logic [31:0] wd, input int waits);
        logic [3:0]  be;
        logic [31:0] wdr;
        int          strobes = 0;
        int          stalls  = 0;
        logic        done    = 1'b0;
        be  = exp_be(ty, addr[1:0]);
        wdr = exp_wd(ty, wd);
        wait_cfg = waits;
        memory_read_memory  = rd;
        memory_write_memory = wr;
        access_type_memory  = ty;
        ALU_output_memory   = addr;
        write_data_memory   = wd;
        if (wr) begin
            for (int l = 0; l < 4; l++)
                if (be[l]) ref_mem[addr[7:2]][8*l +: 8] = wdr[8*l +: 8];
            exp_q.push_back(last_rd);
        end else begin
            exp_q.push_back(ext_load(ref_mem[addr[7:2]], addr[1:0], ty));
        end
        #1;
        check("c0_no_strobe", {30'h0, data_read, data_write}, 32'h0);
        check("c0_stall", {31'h0, stall_memory}, 32'h1);
        check("c0_addr_err", {31'h0, address_error_memory}, 32'h0);
        stalls = 1;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (data_read || data_write) begin
                strobes++;
                if (stall_memory) stalls++;
                check("bus_kind", {30'h0, data_read, data_write}, {30'h0, rd & ~wr, wr});
                check("bus_addr", data_address, {addr[31:2], 2'b00});
                check("bus_be", {28'h0, data_byteenable}, {28'h0, be});
                if (wr) check("bus_wdata", data_writedata, wdr);
            end else begin
                done = 1'b1;
                check("done_stall", {31'h0, stall_memory}, 32'h0);
            end
        end
        check("done_reached", {31'h0, done}, 32'h1);
        check("strobe_cycles", strobes, waits + 1);
        check("stall_cycles", stalls, waits + 2);
        if (exp_q.size() != 0) begin
            last_rd = exp_q.pop_front();
            check("read_data", read_data_memory, last_rd);
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic run_misaligned(input logic [2:0] ty, input logic [31:0] addr);
        memory_read_memory = 1'b1;
        access_type_memory = ty;
        ALU_output_memory  = addr;
        #1;
        check("mis_addr_err", {31'h0, address_error_memory}, 32'h1);
        check("mis_stall", {31'h0, stall_memory}, 32'h0);
        @(negedge clk);
        check("mis_no_strobe", {30'h0, data_read, data_write}, 32'h0);
        check("mis_rd_keep", read_data_memory, last_rd);
        clear_inputs();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        for (int i = 0; i < 64; i++) preload(i, 32'h0);
        preload(4, 32'h8899_AABB);
        @(negedge clk);
        @(negedge clk);
        check("rst_read", {31'h0, data_read}, 32'h0);
        check("rst_write", {31'h0, data_write}, 32'h0);
        check("rst_be", {28'h0, data_byteenable}, 32'h0);
        check("rst_addr", data_address, 32'h0);
        check("rst_wdata", data_writedata, 32'h0);
        check("rst_rdata", read_data_memory, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_stall", {31'h0, stall_memory}, 32'h0);

        // LW, zero wait
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 0);
        // LB / LBU lane 3 with sign bit set
        preload(4, 32'h8012_3456);
        @(negedge clk);
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'h0, 0);
        run_access(1'b1, 1'b0, 3'b100, 32'h0000_0013, 32'h0, 1);
        // SH upper half, 3 wait states; then read back pieces
        run_access(1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h0000_1234, 3);
        run_access(1'b1, 1'b0, 3'b101, 32'h0000_0012, 32'h0, 0);
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_0010, 32'h0, 2);
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_0011, 32'h0, 0);
        // SB lane 1, then whole word
        run_access(1'b0, 1'b1, 3'b100, 32'h0000_0011, 32'h0000_00A5, 0);
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 0);
        // Misaligned accesses
        run_misaligned(3'b010, 32'h0000_0006);
        run_misaligned(3'b101, 32'h0000_0013);

        // Reset while a load sits in BUS with waitrequest high
        wait_cfg = 1000;
        memory_read_memory = 1'b1;
        access_type_memory = 3'b010;
        ALU_output_memory  = 32'h0000_0010;
        @(negedge clk);
        check("pre_rst_read", {31'h0, data_read}, 32'h1);
        clear_inputs();
        #2 reset = 1'b1;
        #1;
        check("async_rst_read", {31'h0, data_read}, 32'h0);
        check("async_rst_stall", {31'h0, stall_memory}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        last_rd = 32'h0;
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 0);

        // Back-to-back SW then LW at the same address
        run_access(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF, 1);
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0, 0);
        // Both strobes requested: store wins
        run_access(1'b1, 1'b1, 3'b010, 32'h0000_0024, 32'hCAFE_F00D, 0);
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0024, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
